// File: rtl/map_ss_pkg.sv
// Shared types and defaults for the mapper save-state sequencer.
package map_ss_pkg;

  localparam int SS_AW       = 8;
  localparam int SS_LEN_DEF  = 128;
  localparam int M2_HALF_DEF = 4;
  localparam int SETTLE_DEF  = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CAPTURE,
    ST_PUSH,
    ST_FETCH,
    ST_STRB_HI,
    ST_STRB_LO,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_SAVE = 1'b0,
    MODE_LOAD = 1'b1
  } mode_t;

endpackage

// File: rtl/ss_m2_gen.sv
// m2-style strobe: start raises ss_m2 for HALF cycles, then HALF cycles low.
// phase_end marks the last cycle of each half while hold is asserted.
module ss_m2_gen
  import map_ss_pkg::*;
#(
  parameter int HALF = M2_HALF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  output logic ss_m2,
  output logic phase_end
);

  localparam int CW = $clog2(HALF);

  logic [CW-1:0] cnt;

  assign phase_end = hold && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      ss_m2 <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(HALF - 1);
      ss_m2 <= 1'b1;
    end else if (hold) begin
      if (cnt == '0) begin
        cnt   <= CW'(HALF - 1);
        ss_m2 <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else begin
      // Outside a strobe the line is forced low so an abort never leaves it high.
      cnt   <= '0;
      ss_m2 <= 1'b0;
    end
  end

endmodule

// File: rtl/map_ss_seq.sv
// Save-state sequencer: streams mapper registers out (save) or replays a stream in (load).
// Save: 1+SETTLE+2 cycles per byte unstalled; load: 2*M2_HALF+2 cycles per byte minimum.
// Backpressure via so_ready/si_valid; SS_CSUM_EN appends/checks a trailing XOR byte.
module map_ss_seq
  import map_ss_pkg::*;
#(
  parameter int SS_LEN  = SS_LEN_DEF,
  parameter int M2_HALF = M2_HALF_DEF,
  parameter int SETTLE  = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_save,
  input  logic             cmd_load,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       so_dat,
  output logic             so_valid,
  input  logic             so_ready,
  input  logic [7:0]       si_dat,
  input  logic             si_valid,
  output logic             si_ready,
  output logic             ss_act,
  output logic [SS_AW-1:0] ss_addr,
  output logic             ss_we,
  output logic [7:0]       ss_wdat,
  output logic             ss_m2,
  input  logic [7:0]       ss_rdat
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SS_AW-1:0] LAST_IDX = SS_AW'(SS_LEN - 1);
`ifdef SS_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  state_t         state, state_nxt;
  mode_t          mode;
  logic [SCW-1:0] settle_cnt;
  logic           accept, last_idx, csum_ph;
  logic           strb_start, strb_hold, phase_end;
  logic [7:0]     csum;

  assign accept     = (state == ST_IDLE) && (cmd_save || cmd_load);
  assign last_idx   = (ss_addr == LAST_IDX);
  assign strb_start = (state == ST_FETCH) && si_valid && !csum_ph;
  assign strb_hold  = (state == ST_STRB_HI) || (state == ST_STRB_LO);

  ss_m2_gen #(.HALF(M2_HALF)) u_m2 (
    .clk       (clk),
    .rst       (rst),
    .start     (strb_start),
    .hold      (strb_hold),
    .ss_m2     (ss_m2),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_save)      state_nxt = ST_SETUP;
        else if (cmd_load) state_nxt = ST_FETCH;
      end
      ST_SETUP:   if (settle_cnt == '0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_PUSH;
      ST_PUSH:    if (so_ready) state_nxt = ST_NEXT;
      ST_FETCH:   if (si_valid) state_nxt = csum_ph ? ST_NEXT : ST_STRB_HI;
      ST_STRB_HI: if (phase_end) state_nxt = ST_STRB_LO;
      ST_STRB_LO: if (phase_end) state_nxt = ST_NEXT;
      ST_NEXT: begin
        // The checksum byte reuses CAPTURE/FETCH at the last index.
        if (!last_idx)                state_nxt = (mode == MODE_SAVE) ? ST_SETUP : ST_FETCH;
        else if (CSUM_EN && !csum_ph) state_nxt = (mode == MODE_SAVE) ? ST_CAPTURE : ST_FETCH;
        else                          state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE) && (state != ST_DONE);
    ss_act   = busy;
    done     = (state == ST_DONE);
    so_valid = (state == ST_PUSH);
    si_ready = (state == ST_FETCH);
    ss_we    = strb_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= MODE_SAVE;
      ss_addr    <= '0;
      so_dat     <= '0;
      ss_wdat    <= '0;
      settle_cnt <= '0;
    end else begin
      if (accept) begin
        mode    <= cmd_save ? MODE_SAVE : MODE_LOAD;
        ss_addr <= '0;
      end
      if ((state == ST_NEXT) && !last_idx)
        ss_addr <= ss_addr + SS_AW'(1);
      if ((state_nxt == ST_SETUP) && (state != ST_SETUP))
        settle_cnt <= SCW'(SETTLE - 1);
      else if ((state == ST_SETUP) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - 1'b1;
      if (state == ST_CAPTURE)
        so_dat <= csum_ph ? csum : ss_rdat;
      if (strb_start)
        ss_wdat <= si_dat;
    end
  end

`ifdef SS_CSUM_EN
  logic err_r;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      csum    <= '0;
      csum_ph <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if ((state == ST_NEXT) && last_idx && !csum_ph)
        csum_ph <= 1'b1;
      if ((state == ST_PUSH) && so_ready && !csum_ph)
        csum <= csum ^ so_dat;
      if ((state == ST_FETCH) && si_valid) begin
        if (!csum_ph)           csum  <= csum ^ si_dat;
        else if (si_dat != csum) err_r <= 1'b1;
      end
    end
  end

  assign err = err_r;
`else
  assign csum    = '0;
  assign csum_ph = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_map_ss_seq.sv
// Scoreboard bench for map_ss_seq with a mock mapper; checksum cases under SS_CSUM_EN.
module tb_map_ss_seq;
  import map_ss_pkg::*;

  localparam int N = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_save = 1'b0, cmd_load = 1'b0;
  logic       busy, done, err;
  logic [7:0] so_dat;
  logic       so_valid;
  logic       so_ready = 1'b0;
  logic [7:0] si_dat = 8'h00;
  logic       si_valid = 1'b0;
  logic       si_ready;
  logic       ss_act, ss_we, ss_m2;
  logic [7:0] ss_addr, ss_wdat, ss_rdat;

  logic [7:0]  mreg[256];
  logic [7:0]  mreg_init[256];
  logic [7:0]  stream[N];
  bit          mock_load = 1'b0;
  logic [7:0]  so_q[$];
  logic [15:0] wr_q[$];
  int          hs_cyc[$];
  int          checks = 0, errors = 0;
  int          so_cnt = 0, fall_cnt = 0, wr_cnt = 0, rise_cnt = 0, cyc = 0;
  bit          prev_m2 = 1'b0, prev_we = 1'b0;
`ifdef SS_CSUM_EN
  bit          csum_bad = 1'b0;
`endif

  assign ss_rdat = mreg[ss_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  map_ss_seq dut (
    .clk(clk), .rst(rst), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .busy(busy), .done(done), .err(err),
    .so_dat(so_dat), .so_valid(so_valid), .so_ready(so_ready),
    .si_dat(si_dat), .si_valid(si_valid), .si_ready(si_ready),
    .ss_act(ss_act), .ss_addr(ss_addr), .ss_we(ss_we), .ss_wdat(ss_wdat),
    .ss_m2(ss_m2), .ss_rdat(ss_rdat)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor and mock mapper: pops the scoreboards on stream handshakes and m2 falls.
  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [15:0] ew;
    if (mock_load) mreg = mreg_init;
    if (!rst && so_valid && so_ready) begin
      so_cnt++;
      hs_cyc.push_back(cyc);
      if (so_q.size() == 0) chk("so extra byte", so_dat, -1);
      else begin
        eb = so_q.pop_front();
        chk("so_dat", so_dat, eb);
      end
    end
    if (prev_m2 && !ss_m2) begin
      fall_cnt++;
      if (ss_we && prev_we) begin
        wr_cnt++;
        mreg[ss_addr] = ss_wdat;
        if (wr_q.size() == 0) chk("unexpected write", ss_addr, -1);
        else begin
          ew = wr_q.pop_front();
          chk("wr addr", ss_addr, ew[15:8]);
          chk("wr data", ss_wdat, ew[7:0]);
        end
      end
    end
    if (!prev_m2 && ss_m2) rise_cnt++;
    prev_m2 = ss_m2;
    prev_we = ss_we;
  end

  task automatic set_mock();
    mock_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 mock_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_basic(input logic [7:0] b0);
    for (int i = 0; i < 256; i++) mreg_init[i] = 8'hFF;
    mreg_init[0]   = b0;
    mreg_init[N-1] = 8'h2A;
  endtask

  task automatic push_save_exp();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < N; i++) begin
      so_q.push_back(mreg_init[i]);
      x ^= mreg_init[i];
    end
`ifdef SS_CSUM_EN
    so_q.push_back(x);
`else
    if (x == 8'h00) x = 8'h01;
`endif
  endtask

  task automatic pulse(input bit s, input bit l);
    cmd_save = s;
    cmd_load = l;
    @(negedge clk);
    cmd_save = 1'b0;
    cmd_load = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done"}, done, 1);
    chk({nm, " addr at done"}, ss_addr, N - 1);
    @(negedge clk);
    chk({nm, " ss_act after"}, ss_act, 0);
    chk({nm, " busy after"}, busy, 0);
  endtask

  task automatic load_byte(input logic [7:0] b);
    int n;
    si_dat   = b;
    si_valid = 1'b1;
    n = 0;
    while (!si_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("si handshake", si_ready, 1);
    if (si_ready) @(negedge clk);
    si_valid = 1'b0;
  endtask

  task automatic run_load(input int nb);
`ifdef SS_CSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    for (int i = 0; i < nb; i++) wr_q.push_back({8'(i), stream[i]});
    pulse(1'b0, 1'b1);
    for (int i = 0; i < nb; i++) begin
      load_byte(stream[i]);
`ifdef SS_CSUM_EN
      x ^= stream[i];
`endif
    end
`ifdef SS_CSUM_EN
    load_byte(csum_bad ? 8'h00 : x);
`endif
  endtask

  function automatic int n_save();
`ifdef SS_CSUM_EN
    return N + 1;
`else
    return N;
`endif
  endfunction

  initial begin
    int base, bfall, bwr, brise, hb, c0, n, h0, h1;

    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);     chk("rst done", done, 0);
    chk("rst err", err, 0);       chk("rst so_valid", so_valid, 0);
    chk("rst si_ready", si_ready, 0); chk("rst ss_act", ss_act, 0);
    chk("rst ss_addr", ss_addr, 0);   chk("rst ss_we", ss_we, 0);
    chk("rst ss_wdat", ss_wdat, 0);   chk("rst ss_m2", ss_m2, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic save: 0x02, 126 x 0xFF, 0x2A (then 0x28 with checksum).
    fill_basic(8'h02);
    set_mock();
    push_save_exp();
    base = so_cnt; bfall = fall_cnt; hb = hs_cyc.size();
    so_ready = 1'b1;
    c0 = cyc;
    pulse(1'b1, 1'b0);
    wait_done("save1");
    chk("save1 bytes", so_cnt - base, n_save());
    chk("save1 queue empty", so_q.size(), 0);
    chk("save1 no m2 edges", fall_cnt - bfall, 0);
    h0 = (hs_cyc.size() > hb) ? hs_cyc[hb] : -1000;
    h1 = (hs_cyc.size() > hb + 1) ? hs_cyc[hb+1] : -1000;
    chk("save1 first latency", h0 - c0, 4);
    chk("save1 byte period", h1 - h0, 5);

    // Save with a 10-cycle stall on byte 5.
    for (int i = 0; i < 256; i++) mreg_init[i] = 8'(i + 64);
    set_mock();
    push_save_exp();
    base = so_cnt;
    so_ready = 1'b1;
    pulse(1'b1, 1'b0);
    n = 0;
    while (so_cnt - base < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 so_ready = 1'b0;
    @(negedge clk);
    n = 0;
    while (!so_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      chk("stall so_valid", so_valid, 1);
      chk("stall so_dat", so_dat, mreg_init[5]);
      @(negedge clk);
    end
    @(posedge clk);
    #1 so_ready = 1'b1;
    @(negedge clk);
    wait_done("stall");
    chk("stall bytes", so_cnt - base, n_save());
    chk("stall queue empty", so_q.size(), 0);

    // Simultaneous commands: save wins; cmd_load while busy is ignored.
    fill_basic(8'h02);
    set_mock();
    push_save_exp();
    base = so_cnt;
    pulse(1'b1, 1'b1);
    chk("both si_ready", si_ready, 0);
    chk("both busy", busy, 1);
    repeat (20) @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_done("both");
    chk("both bytes", so_cnt - base, n_save());
    chk("both queue empty", so_q.size(), 0);

    // Load 0x03, 126 x 0xFF, 0x2A into a zeroed mock.
    for (int i = 0; i < 256; i++) mreg_init[i] = 8'h00;
    set_mock();
    for (int i = 0; i < N; i++) stream[i] = 8'hFF;
    stream[0] = 8'h03; stream[N-1] = 8'h2A;
    bfall = fall_cnt; bwr = wr_cnt;
    run_load(N);
    wait_done("load");
    chk("load m2 falls", fall_cnt - bfall, N);
    chk("load writes", wr_cnt - bwr, N);
    chk("load chr_bank", mreg[0], 8'h03);
    chk("load idx64", mreg[64], 8'hFF);
    chk("load idx127", mreg[N-1], 8'h2A);
    chk("load err", err, 0);
    chk("load wr queue empty", wr_q.size(), 0);

    // Reset after the third strobe rises: abort with no further writes.
    for (int i = 0; i < 3; i++) stream[i] = 8'(8'h10 + i);
    wr_q.push_back({8'd0, 8'h10});
    wr_q.push_back({8'd1, 8'h11});
    brise = rise_cnt; bwr = wr_cnt;
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) load_byte(stream[i]);
    n = 0;
    while (rise_cnt - brise < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort rises", rise_cnt - brise, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort ss_act", ss_act, 0);
    chk("abort ss_m2", ss_m2, 0);
    chk("abort ss_we", ss_we, 0);
    chk("abort busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort idx0", mreg[0], 8'h10);
    chk("abort idx1", mreg[1], 8'h11);
    chk("abort idx2", mreg[2], 8'hFF);
    chk("abort idx127", mreg[N-1], 8'h2A);
    chk("abort writes", wr_cnt - bwr, 2);
    chk("abort wr queue empty", wr_q.size(), 0);

`ifdef SS_CSUM_EN
    // Bad trailing checksum: registers written, err raised.
    for (int i = 0; i < 256; i++) mreg_init[i] = 8'h00;
    set_mock();
    for (int i = 0; i < N; i++) stream[i] = 8'hFF;
    stream[0] = 8'h03; stream[N-1] = 8'h2A;
    csum_bad = 1'b1;
    run_load(N);
    wait_done("csum bad");
    chk("csum bad err", err, 1);
    chk("csum bad chr_bank", mreg[0], 8'h03);
    chk("csum bad wr queue empty", wr_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
